// File: rtl/tune_pkg.sv
// Shared constants and types for the NCO tuning controller: command bytes,
// FSM state encoding, default increments and saturation bounds.
package tune_pkg;

  // Increments for a 136 MHz sample clock.
  localparam logic [63:0] RESET_INC   = 64'h0104376A9DD10437; // 540 kHz
  localparam logic [63:0] STEP_COARSE = 64'h00045641C6E59DF0; // 9 kHz
  localparam logic [63:0] STEP_FINE   = 64'h00007B5CA45266E2; // 1 kHz
  localparam logic [63:0] INC_MIN     = 64'h0;
  localparam logic [63:0] INC_MAX     = 64'h3FFFFFFFFFFFFFFF; // Fclk/4

  // 10 ms inter-byte timeout at 136 MHz.
  localparam int unsigned TIMEOUT_CLKS_DEF = 1360000;

  // ASCII command and reply bytes.
  localparam logic [7:0] CMD_SET = 8'h53; // 'S'
  localparam logic [7:0] CMD_UP  = 8'h55; // 'U'
  localparam logic [7:0] CMD_DN  = 8'h44; // 'D'
  localparam logic [7:0] CMD_FUP = 8'h75; // 'u'
  localparam logic [7:0] CMD_FDN = 8'h64; // 'd'
  localparam logic [7:0] CMD_RD  = 8'h52; // 'R'
  localparam logic [7:0] RSP_ACK = 8'h4B; // 'K'
  localparam logic [7:0] RSP_ERR = 8'h3F; // '?'

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_APPLY    = 3'd2,
    ST_TX_START = 3'd3,
    ST_TX_WAIT  = 3'd4
  } state_e;

  // Update selected for the APPLY cycle.
  typedef enum logic [2:0] {
    OP_SET = 3'd0,
    OP_UP  = 3'd1,
    OP_DN  = 3'd2,
    OP_FUP = 3'd3,
    OP_FDN = 3'd4
  } op_e;

  // Byte idx of a 64-bit word, idx 0 = most significant byte.
  function automatic logic [7:0] byte_of(input logic [63:0] v, input logic [2:0] idx);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (idx == 3'(i)) r = v[8*(7-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/tune_sat_add.sv
// Combinational 64-bit add/subtract saturated to [INC_MIN, INC_MAX].
// A set-clamp is an add with b_i = 0.
module tune_sat_add
  import tune_pkg::*;
(
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic        sub_i,
  output logic [63:0] y_o
);

  logic [65:0] sum;
  logic [65:0] diff;
  logic [65:0] sum_lo;
  logic [65:0] diff_lo;

  // Wide arithmetic so carries/borrows against both bounds are visible as bit 65/64.
  always_comb begin
    sum     = {2'b00, a_i} + {2'b00, b_i};
    diff    = {2'b00, a_i} - {2'b00, b_i};
    sum_lo  = sum  - {2'b00, INC_MIN};
    diff_lo = diff - {2'b00, INC_MIN};
    y_o     = 64'h0;
    if (sub_i) begin
      // Borrow out of the subtraction, or landing below the floor.
      if (diff[65] || diff_lo[65]) y_o = INC_MIN;
      else if (diff[63:0] > INC_MAX) y_o = INC_MAX;
      else y_o = diff[63:0];
    end else begin
      if (sum[64] || (sum[63:0] > INC_MAX)) y_o = INC_MAX;
      else if (sum_lo[65]) y_o = INC_MIN;
      else y_o = sum[63:0];
    end
  end

endmodule

// File: rtl/tune_ctrl.sv
// UART-driven tuning controller for the local-oscillator NCO increment.
//
// Handshakes: rx_dv is a one-cycle strobe qualifying rx_byte (no back
// pressure, so a byte is buffered, consumed, or dropped with overrun set).
// tx_dv is a one-cycle strobe; tx_byte stays stable until uart_tx returns
// the one-cycle tx_done strobe, which is only honoured in TX_WAIT.
module tune_ctrl
  import tune_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
  input  logic        osc_clk,
  input  logic        reset,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  input  logic        tx_done,
  output logic [63:0] phase_inc_carr,
  output logic        inc_update,
  output logic        overrun,
  output logic [2:0]  dbg_state_o
);

  localparam int TMO_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  logic [1:0]       rst_sync_q;
  logic             rst_n;
  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [63:0]      inc_q, inc_d;
  logic [63:0]      shadow_q, shadow_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             pend_vld_q, pend_vld_d;
  logic [7:0]       pend_byte_q, pend_byte_d;
  logic [7:0]       rsp_q, rsp_d;
  logic             rd_q, rd_d;
  logic [3:0]       rd_idx_q, rd_idx_d;
  logic             tx_dv_q, tx_dv_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             inc_update_q, inc_update_d;
  logic             overrun_q, overrun_d;
  logic             byte_vld;
  logic [7:0]       byte_val;
  logic [63:0]      sat_a, sat_b, sat_y;
  logic             sat_sub;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge osc_clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Operand selection for the single APPLY cycle.
  always_comb begin
    sat_a   = inc_q;
    sat_b   = 64'h0;
    sat_sub = 1'b0;
    case (op_q)
      OP_SET:  sat_a = shadow_q;
      OP_UP:   sat_b = STEP_COARSE;
      OP_DN:   begin sat_b = STEP_COARSE; sat_sub = 1'b1; end
      OP_FUP:  sat_b = STEP_FINE;
      OP_FDN:  begin sat_b = STEP_FINE;   sat_sub = 1'b1; end
      default: ;
    endcase
  end

  tune_sat_add u_sat (
    .a_i  (sat_a),
    .b_i  (sat_b),
    .sub_i(sat_sub),
    .y_o  (sat_y)
  );

  // Input buffering, command decode and reply sequencing.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    inc_d        = inc_q;
    shadow_d     = shadow_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    pend_vld_d   = pend_vld_q;
    pend_byte_d  = pend_byte_q;
    rsp_d        = rsp_q;
    rd_d         = rd_q;
    rd_idx_d     = rd_idx_q;
    tx_dv_d      = 1'b0;
    tx_byte_d    = tx_byte_q;
    inc_update_d = 1'b0;
    overrun_d    = overrun_q;
    byte_vld     = 1'b0;
    byte_val     = rx_byte;

    // Pending byte wins over a same-cycle rx_dv, which then refills pending.
    if ((state_q == ST_IDLE) || (state_q == ST_LOAD)) begin
      if (pend_vld_q) begin
        byte_vld   = 1'b1;
        byte_val   = pend_byte_q;
        pend_vld_d = rx_dv;
        if (rx_dv) pend_byte_d = rx_byte;
      end else if (rx_dv) begin
        byte_vld = 1'b1;
      end
    end else if (rx_dv) begin
      if (pend_vld_q) begin
        overrun_d = 1'b1;
      end else begin
        pend_vld_d  = 1'b1;
        pend_byte_d = rx_byte;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (byte_vld) begin
          case (byte_val)
            CMD_SET: begin
              state_d  = ST_LOAD;
              cnt_d    = 3'd0;
              tmo_d    = '0;
              shadow_d = 64'h0;
            end
            CMD_UP:  begin op_d = OP_UP;  state_d = ST_APPLY; end
            CMD_DN:  begin op_d = OP_DN;  state_d = ST_APPLY; end
            CMD_FUP: begin op_d = OP_FUP; state_d = ST_APPLY; end
            CMD_FDN: begin op_d = OP_FDN; state_d = ST_APPLY; end
            CMD_RD: begin
              rd_d     = 1'b1;
              rd_idx_d = 4'd0;
              state_d  = ST_TX_START;
            end
            default: begin
              rd_d    = 1'b0;
              rsp_d   = RSP_ERR;
              state_d = ST_TX_START;
            end
          endcase
        end
      end
      ST_LOAD: begin
        // Every byte here is frame data, even if it looks like a command.
        if (byte_vld) begin
          shadow_d = {shadow_q[55:0], byte_val};
          tmo_d    = '0;
          cnt_d    = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            op_d    = OP_SET;
            state_d = ST_APPLY;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CLKS - 1)) begin
          shadow_d = 64'h0;
          state_d  = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_APPLY: begin
        inc_d        = sat_y;
        inc_update_d = 1'b1;
        rd_d         = 1'b0;
        rsp_d        = RSP_ACK;
        state_d      = ST_TX_START;
      end
      ST_TX_START: begin
        tx_dv_d = 1'b1;
        if (rd_q) tx_byte_d = (rd_idx_q == 4'd8) ? RSP_ACK : byte_of(inc_q, rd_idx_q[2:0]);
        else      tx_byte_d = rsp_q;
        state_d = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (tx_done) begin
          if (rd_q && (rd_idx_q != 4'd8)) begin
            rd_idx_d = rd_idx_q + 4'd1;
            state_d  = ST_TX_START;
          end else begin
            rd_d    = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_SET;
      inc_q        <= RESET_INC;
      shadow_q     <= 64'h0;
      cnt_q        <= 3'd0;
      tmo_q        <= '0;
      pend_vld_q   <= 1'b0;
      pend_byte_q  <= 8'h00;
      rsp_q        <= 8'h00;
      rd_q         <= 1'b0;
      rd_idx_q     <= 4'd0;
      tx_dv_q      <= 1'b0;
      tx_byte_q    <= 8'h00;
      inc_update_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      inc_q        <= inc_d;
      shadow_q     <= shadow_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      pend_vld_q   <= pend_vld_d;
      pend_byte_q  <= pend_byte_d;
      rsp_q        <= rsp_d;
      rd_q         <= rd_d;
      rd_idx_q     <= rd_idx_d;
      tx_dv_q      <= tx_dv_d;
      tx_byte_q    <= tx_byte_d;
      inc_update_q <= inc_update_d;
      overrun_q    <= overrun_d;
    end
  end

  assign phase_inc_carr = inc_q;
  assign tx_dv          = tx_dv_q;
  assign tx_byte        = tx_byte_q;
  assign inc_update     = inc_update_q;
  assign overrun        = overrun_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_tune_ctrl.sv
// Bench for tune_ctrl: directed commands, expected tx bytes and increments
// pushed into queues, and a monitor that pops on tx_dv / inc_update.
module tb_tune_ctrl;
  import tune_pkg::*;

  logic        osc_clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_done = 1'b0;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic [63:0] phase_inc_carr;
  logic        inc_update;
  logic        overrun;
  logic [2:0]  dbg_state;

  logic [7:0]  exp_q[$];
  logic [63:0] inc_exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_rx_cyc = 0;
  int          inc_cyc = 0;
  int          tx_cnt = 0;
  bit          lat_chk = 1'b0;
  bit          tx_lat_chk = 1'b0;
  bit          hold_done = 1'b0;
  logic [63:0] prev_inc = 64'h0;

  tune_ctrl #(.TIMEOUT_CLKS(100)) dut (
    .osc_clk       (osc_clk),
    .reset         (reset),
    .rx_dv         (rx_dv),
    .rx_byte       (rx_byte),
    .tx_dv         (tx_dv),
    .tx_byte       (tx_byte),
    .tx_done       (tx_done),
    .phase_inc_carr(phase_inc_carr),
    .inc_update    (inc_update),
    .overrun       (overrun),
    .dbg_state_o   (dbg_state)
  );

  // Clock and cycle counter
  always #5 osc_clk = ~osc_clk;
  always @(posedge osc_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check64(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic check8(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Driver: one rx_dv strobe, then one idle cycle.
  task automatic send_byte(input logic [7:0] b);
    @(posedge osc_clk);
    #1;
    rx_dv = 1'b1;
    rx_byte = b;
    last_rx_cyc = cyc;
    @(posedge osc_clk);
    #1;
    rx_dv = 1'b0;
  endtask

  task automatic set_frame(input logic [63:0] v, input logic [63:0] exp_inc);
    inc_exp_q.push_back(exp_inc);
    exp_q.push_back(RSP_ACK);
    send_byte(CMD_SET);
    for (int i = 7; i >= 0; i--) send_byte(v[8*i +: 8]);
  endtask

  task automatic step_cmd(input logic [7:0] c, input logic [63:0] exp_inc);
    inc_exp_q.push_back(exp_inc);
    exp_q.push_back(RSP_ACK);
    send_byte(c);
  endtask

  task automatic wait_quiet();
    int n;
    int stable;
    n = 0;
    stable = 0;
    while (n < 3000 && stable < 4) begin
      @(posedge osc_clk);
      n++;
      if (exp_q.size() == 0 && inc_exp_q.size() == 0 && dbg_state == ST_IDLE) stable++;
      else stable = 0;
    end
    if (stable < 4) begin
      errors++;
      checks++;
      $display("FAIL wait_quiet timeout tx_left=%0d inc_left=%0d", exp_q.size(), inc_exp_q.size());
    end
  endtask

  task automatic wait_tx_cnt(input int target);
    int n;
    n = 0;
    while (n < 2000 && tx_cnt < target) begin
      @(posedge osc_clk);
      n++;
    end
    if (tx_cnt < target) begin
      errors++;
      checks++;
      $display("FAIL wait_tx timeout got=%0d exp=%0d", tx_cnt, target);
    end
  endtask

  // uart_tx model: answers each tx_dv with tx_done a few cycles later, unless held.
  initial begin
    int n;
    forever begin
      @(negedge osc_clk);
      if (reset && tx_dv) begin
        n = 0;
        while (reset && (n < 3 || hold_done)) begin
          @(posedge osc_clk);
          n++;
        end
        #1 tx_done = 1'b1;
        @(posedge osc_clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge osc_clk) begin
    if (reset) begin
      if (tx_dv) begin
        tx_cnt++;
        if (tx_lat_chk) begin
          tx_lat_chk = 1'b0;
          check_int("tx_latency", cyc - inc_cyc, 1);
        end
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL tx_unexpected got=%h exp=none", tx_byte);
        end else begin
          check8("tx_byte", tx_byte, exp_q.pop_front());
        end
      end
      if (inc_update) begin
        inc_cyc = cyc;
        tx_lat_chk = 1'b1;
        if (lat_chk) begin
          lat_chk = 1'b0;
          check_int("inc_latency", cyc - last_rx_cyc, 2);
        end
        if (inc_exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL inc_unexpected got=%h exp=none", phase_inc_carr);
        end else begin
          check64("phase_inc", phase_inc_carr, inc_exp_q.pop_front());
        end
      end else begin
        check64("inc_stable", phase_inc_carr, prev_inc);
      end
    end
    prev_inc = phase_inc_carr;
  end

  initial begin
    int base;
    repeat (4) @(posedge osc_clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge osc_clk);
    @(negedge osc_clk);
    check64("reset_inc", phase_inc_carr, 64'h0104376A9DD10437);
    check8("reset_tx_dv", {7'd0, tx_dv}, 8'h00);
    check8("reset_tx_byte", tx_byte, 8'h00);
    check8("reset_overrun", {7'd0, overrun}, 8'h00);
    check8("reset_inc_update", {7'd0, inc_update}, 8'h00);

    // Coarse up from the reset value, with latency checks
    lat_chk = 1'b1;
    step_cmd(CMD_UP, 64'h01088DAC64B6A227);
    wait_quiet();
    check64("after_up", phase_inc_carr, 64'h01088DAC64B6A227);

    // Full set frame, then readback
    lat_chk = 1'b1;
    set_frame(64'h01B1B1B1B1B1B1B1, 64'h01B1B1B1B1B1B1B1);
    wait_quiet();
    exp_q.push_back(8'h01);
    for (int i = 0; i < 7; i++) exp_q.push_back(8'hB1);
    exp_q.push_back(RSP_ACK);
    send_byte(CMD_RD);
    wait_quiet();

    // Partial frame times out; the following 'u' is a command
    send_byte(CMD_SET);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (101) @(posedge osc_clk);
    check8("timeout_state", {5'd0, dbg_state}, {5'd0, ST_IDLE});
    step_cmd(CMD_FUP, 64'h01B22D0E56041893);
    wait_quiet();
    check64("after_timeout_fup", phase_inc_carr, 64'h01B22D0E56041893);

    // Saturation at both bounds and clamp on set
    set_frame(64'h3FFFFFFFFFFFF000, 64'h3FFFFFFFFFFFF000);
    step_cmd(CMD_UP, 64'h3FFFFFFFFFFFFFFF);
    wait_quiet();
    check64("sat_max", phase_inc_carr, 64'h3FFFFFFFFFFFFFFF);
    set_frame(64'hFFFF000000000001, 64'h3FFFFFFFFFFFFFFF);
    wait_quiet();
    set_frame(64'h0000000000000010, 64'h0000000000000010);
    step_cmd(CMD_DN, 64'h0);
    wait_quiet();
    check64("sat_min", phase_inc_carr, 64'h0);

    // Pending buffer and overrun while the reply is held
    hold_done = 1'b1;
    base = tx_cnt;
    step_cmd(CMD_DN, 64'h0);
    wait_tx_cnt(base + 1);
    step_cmd(CMD_FUP, 64'h00007B5CA45266E2);
    hold_done = 1'b0;
    base = 0;
    while (base < 200 && inc_exp_q.size() != 0) begin
      @(posedge osc_clk);
      base++;
    end
    hold_done = 1'b1;
    step_cmd(CMD_FDN, 64'h0);
    @(negedge osc_clk);
    check8("overrun_before", {7'd0, overrun}, 8'h00);
    send_byte(CMD_UP);
    @(negedge osc_clk);
    check8("overrun_set", {7'd0, overrun}, 8'h01);
    hold_done = 1'b0;
    wait_quiet();
    check64("after_overrun", phase_inc_carr, 64'h0);
    check8("overrun_sticky", {7'd0, overrun}, 8'h01);

    // Unknown byte
    exp_q.push_back(RSP_ERR);
    send_byte(8'h41);
    wait_quiet();
    repeat (10) @(posedge osc_clk);
    check64("after_unknown", phase_inc_carr, 64'h0);

    // Reset in the middle of a readback
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h00);
    exp_q.push_back(RSP_ACK);
    base = tx_cnt;
    send_byte(CMD_RD);
    wait_tx_cnt(base + 3);
    #1 reset = 1'b0;
    exp_q.delete();
    repeat (3) begin
      @(negedge osc_clk);
      check8("rst_tx_dv", {7'd0, tx_dv}, 8'h00);
    end
    check64("rst_inc", phase_inc_carr, 64'h0104376A9DD10437);
    check8("rst_overrun", {7'd0, overrun}, 8'h00);
    @(posedge osc_clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge osc_clk);
    @(negedge osc_clk);
    check64("post_rst_inc", phase_inc_carr, 64'h0104376A9DD10437);
    check8("post_rst_tx_byte", tx_byte, 8'h00);

    // Controller works again after reset
    lat_chk = 1'b1;
    step_cmd(CMD_FDN, 64'h0103BC0DF97E9D55);
    wait_quiet();
    check64("post_rst_fdn", phase_inc_carr, 64'h0103BC0DF97E9D55);
    check_int("queues_empty", exp_q.size() + inc_exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
